// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 parallel-bus engines: op codes, reader FSM states
// and default bus timing in clock cycles.
package lcd_pkg;

  typedef enum logic [1:0] {
    OP_STATUS = 2'b00,
    OP_DATA   = 2'b01,
    OP_POLL   = 2'b10
  } lcd_op_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EHIGH,
    HOLD,
    REC,
    DONE
  } lcd_state_e;

  localparam int LCD_T_AS     = 3;
  localparam int LCD_T_PW     = 24;
  localparam int LCD_T_H      = 2;
  localparam int LCD_T_REC    = 24;
  localparam int LCD_POLL_MAX = 1024;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // The reserved encoding 2'b11 falls back to a single status read.
  function automatic lcd_op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'b01:   return OP_DATA;
      2'b10:   return OP_POLL;
      default: return OP_STATUS;
    endcase
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter shared by every timed bus phase; expire_o is high while the
// count sits at zero, so loading N-1 yields a phase lasting N cycles.
module lcd_phase_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// RW=1 read engine for the HD44780 bus: single status/data reads and busy-flag polling
// with a bounded number of reads. All bus strobes are registered.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_AS     = LCD_T_AS,
  parameter int T_PW     = LCD_T_PW,
  parameter int T_H      = LCD_T_H,
  parameter int T_REC    = LCD_T_REC,
  parameter int POLL_MAX = LCD_POLL_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] op,
  output logic       ready,
  output logic       valid,
  output logic [7:0] rdata,
  output logic       timeout,
  input  logic [7:0] d_in,
  output logic       d_oe,
  output logic       RS,
  output logic       RW,
  output logic       E
);

  localparam int PH_MAX = max_of4(T_AS, T_PW, T_H, T_REC);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int PC_W   = $clog2(POLL_MAX + 1);

  localparam logic [PH_W-1:0] AS_LD  = PH_W'(T_AS - 1);
  localparam logic [PH_W-1:0] PW_LD  = PH_W'(T_PW - 1);
  localparam logic [PH_W-1:0] H_LD   = PH_W'(T_H - 1);
  localparam logic [PH_W-1:0] REC_LD = PH_W'(T_REC - 1);
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(POLL_MAX);

  lcd_state_e      state_q, state_d;
  lcd_op_e         op_q, op_d;
  logic            rs_q, rs_d;
  logic            rw_q, rw_d;
  logic            e_q, e_d;
  logic            valid_q, valid_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            timeout_q, timeout_d;
  logic [PC_W-1:0] poll_cnt_q, poll_cnt_d;

  logic            tmr_load;
  logic [PH_W-1:0] tmr_val;
  logic            tmr_expire;
  logic            still_busy;

  lcd_phase_timer #(
    .W(PH_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .expire_o(tmr_expire)
  );

  assign still_busy = (op_q == OP_POLL) && rdata_q[7];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs_d       = rs_q;
    rw_d       = rw_q;
    e_d        = e_q;
    valid_d    = 1'b0;
    rdata_d    = rdata_q;
    timeout_d  = timeout_q;
    poll_cnt_d = poll_cnt_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          op_d       = decode_op(op);
          rs_d       = (op == 2'b01);
          rw_d       = 1'b1;
          timeout_d  = 1'b0;
          poll_cnt_d = '0;
          tmr_load   = 1'b1;
          tmr_val    = AS_LD;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (tmr_expire) begin
          e_d      = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = PW_LD;
          state_d  = EHIGH;
        end
      end
      EHIGH: begin
        // The LCD drives d_in while E is high; capture on the falling edge.
        if (tmr_expire) begin
          e_d     = 1'b0;
          rdata_d = d_in;
          if (poll_cnt_q != PC_MAX) begin
            poll_cnt_d = poll_cnt_q + PC_W'(1);
          end
          tmr_load = 1'b1;
          tmr_val  = H_LD;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (tmr_expire) begin
          if (still_busy && (poll_cnt_q < PC_MAX)) begin
            tmr_load = 1'b1;
            tmr_val  = REC_LD;
            state_d  = REC;
          end else begin
            timeout_d = still_busy;
            rs_d      = 1'b0;
            rw_d      = 1'b0;
            valid_d   = 1'b1;
            state_d   = DONE;
          end
        end
      end
      REC: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          tmr_val  = AS_LD;
          state_d  = SETUP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_STATUS;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      e_q        <= 1'b0;
      valid_q    <= 1'b0;
      rdata_q    <= 8'h00;
      timeout_q  <= 1'b0;
      poll_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      e_q        <= e_d;
      valid_q    <= valid_d;
      rdata_q    <= rdata_d;
      timeout_q  <= timeout_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign valid   = valid_q;
  assign rdata   = rdata_q;
  assign timeout = timeout_q;
  assign d_oe    = 1'b0;
  assign RS      = rs_q;
  assign RW      = rw_q;
  assign E       = e_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader (default bus timing, POLL_MAX=4); a negedge monitor
// logs strobe edges and invariants, the main sequence checks each operation.
module tb_lcd_bus_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [1:0] op;
  logic       ready;
  logic       valid;
  logic [7:0] rdata;
  logic       timeout;
  logic [7:0] d_in;
  logic       d_oe;
  logic       RS;
  logic       RW;
  logic       E;

  int checks = 0;
  int errors = 0;

  // Stimulus-side controls for the pad data: d_alt is presented once more than
  // alt_after E pulses of the current operation have started.
  logic [7:0] d_base = 8'h00;
  logic [7:0] d_alt  = 8'h00;
  int         alt_after = 1000;
  int         p0 = 0;

  // Monitor state, written only by the negedge monitor.
  int s = 0;
  int pulses = 0;
  int rise_s = -1;
  int fall_s = -1;
  int acc_s = -1;
  int acc_cnt = 0;
  int acc_gap = -1;
  int gap_cnt = 0;
  int gap_bad = 0;
  int gap_last = -1;
  int hi_bad = 0;
  int valid_cnt = 0;
  int valid_s = -1;
  int rs_hi = 0;
  int rw_hi = 0;
  int e_rw_viol = 0;
  int doe_viol = 0;
  int rs_at_acc = -1;
  logic [7:0] v_rdata = 8'h00;
  logic       v_to = 1'b0;
  logic       e_p = 1'b0;
  logic       rw_p = 1'b0;

  // Per-operation snapshots, written only by the main sequence.
  int vc0, gc0, gb0, hb0, rs0, rw0, a0;

  always #5 clk = ~clk;

  assign d_in = ((pulses - p0) > alt_after) ? d_alt : d_base;

  lcd_bus_reader #(
    .POLL_MAX(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op     (op),
    .ready  (ready),
    .valid  (valid),
    .rdata  (rdata),
    .timeout(timeout),
    .d_in   (d_in),
    .d_oe   (d_oe),
    .RS     (RS),
    .RW     (RW),
    .E      (E)
  );

  always @(negedge clk) begin
    s = s + 1;
    if ((E === 1'b1) && !e_p) begin
      pulses = pulses + 1;
      if (fall_s > acc_s) begin
        gap_cnt = gap_cnt + 1;
        gap_last = s - fall_s;
        if (gap_last != 29) gap_bad = gap_bad + 1;
      end
      rise_s = s;
    end
    if ((E !== 1'b1) && e_p) begin
      fall_s = s;
      if ((s - rise_s) != 24) hi_bad = hi_bad + 1;
    end
    if ((RW === 1'b1) && !rw_p) begin
      if (acc_s >= 0) acc_gap = s - acc_s;
      acc_s = s;
      acc_cnt = acc_cnt + 1;
      rs_at_acc = (RS === 1'b1) ? 1 : 0;
    end
    if (valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      valid_s = s;
      v_rdata = rdata;
      v_to = timeout;
    end
    if (RS === 1'b1) rs_hi = rs_hi + 1;
    if (RW === 1'b1) rw_hi = rw_hi + 1;
    if ((E === 1'b1) && (RW !== 1'b1)) e_rw_viol = e_rw_viol + 1;
    if (d_oe !== 1'b0) doe_viol = doe_viol + 1;
    e_p = (E === 1'b1);
    rw_p = (RW === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input int bound);
    int n;
    vc0 = valid_cnt;
    p0  = pulses;
    gc0 = gap_cnt;
    gb0 = gap_bad;
    hb0 = hi_bad;
    rs0 = rs_hi;
    rw0 = rw_hi;
    @(posedge clk); #1;
    op  = o;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while ((valid_cnt == vc0) && (n < bound)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("op_completes", valid_cnt - vc0, 1);
    $display("op=%0d done: rdata=%02h timeout=%0b pulses=%0d", o, v_rdata, v_to, pulses - p0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req = 1'b0;
    op  = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_timeout", timeout, 0);
    chk("rst_strobes", {RS, RW, E, d_oe}, 4'b0000);

    // Single status read.
    d_base = 8'h05; alt_after = 1000;
    run_op(2'b00, 200);
    chk("st_rdata", v_rdata, 8'h05);
    chk("st_timeout", v_to, 0);
    chk("st_e_rise", rise_s - acc_s, 3);
    chk("st_e_fall", fall_s - acc_s, 27);
    chk("st_valid_at", valid_s - acc_s, 29);
    chk("st_pulses", pulses - p0, 1);
    chk("st_hi_len_bad", hi_bad - hb0, 0);
    chk("st_rs_hi", rs_hi - rs0, 0);
    chk("st_rw_hi", rw_hi - rw0, 29);
    chk("st_ready_after", ready, 1);
    chk("st_valid_low", valid, 0);

    // Single data read.
    d_base = 8'h4A;
    run_op(2'b01, 200);
    chk("dt_rdata", v_rdata, 8'h4A);
    chk("dt_rs_at_accept", rs_at_acc, 1);
    chk("dt_rs_hi", rs_hi - rs0, 29);
    chk("dt_rw_hi", rw_hi - rw0, 29);
    chk("dt_after_rs_rw", {RS, RW}, 2'b00);
    chk("dt_valid_at", valid_s - acc_s, 29);

    // Poll: busy for three reads, then clear.
    d_base = 8'h80; d_alt = 8'h12; alt_after = 3;
    run_op(2'b10, 1000);
    chk("pl_pulses", pulses - p0, 4);
    chk("pl_gaps", gap_cnt - gc0, 3);
    chk("pl_gap_bad", gap_bad - gb0, 0);
    chk("pl_gap_last", gap_last, 29);
    chk("pl_hi_len_bad", hi_bad - hb0, 0);
    chk("pl_rdata", v_rdata, 8'h12);
    chk("pl_timeout", v_to, 0);
    chk("pl_rw_hi", rw_hi - rw0, 188);
    chk("pl_rs_hi", rs_hi - rs0, 0);

    // Poll that never clears: POLL_MAX=4 reads, then timeout.
    d_base = 8'hFF; alt_after = 1000;
    run_op(2'b10, 1000);
    chk("to_pulses", pulses - p0, 4);
    chk("to_timeout", v_to, 1);
    chk("to_rdata", v_rdata, 8'hFF);
    chk("to_rw_hi", rw_hi - rw0, 188);
    repeat (3) @(posedge clk); #1;
    chk("to_held", timeout, 1);

    // Reserved op behaves as a status read and clears the held timeout.
    d_base = 8'hA5;
    run_op(2'b11, 200);
    chk("rsv_rdata", v_rdata, 8'hA5);
    chk("rsv_timeout", v_to, 0);
    chk("rsv_pulses", pulses - p0, 1);
    chk("rsv_rs_hi", rs_hi - rs0, 0);

    // Reset while E is high during a poll.
    d_base = 8'h80; alt_after = 1000;
    vc0 = valid_cnt;
    @(posedge clk); #1;
    op = 2'b10; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while ((E !== 1'b1) && (n < 100)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ar_e_seen", E, 1);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("ar_async_strobes", {E, RW, RS}, 3'b000);
    chk("ar_ready", ready, 1);
    chk("ar_valid", valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (80) @(posedge clk); #1;
    chk("ar_no_valid", valid_cnt - vc0, 0);
    $display("reset abort: valid pulses since start=%0d", valid_cnt - vc0);

    d_base = 8'h33;
    run_op(2'b00, 200);
    chk("ar_after_rdata", v_rdata, 8'h33);
    chk("ar_after_timeout", v_to, 0);
    chk("ar_after_valid_at", valid_s - acc_s, 29);

    // req held high: back-to-back status reads.
    d_base = 8'h5A;
    vc0 = valid_cnt;
    a0  = acc_cnt;
    @(posedge clk); #1;
    op = 2'b00; req = 1'b1;
    n = 0;
    while (((valid_cnt - vc0) < 3) && (n < 500)) begin
      @(posedge clk); #1;
      n++;
    end
    req = 1'b0;
    repeat (40) @(posedge clk); #1;
    chk("bb_valids", valid_cnt - vc0, 3);
    chk("bb_accepts", acc_cnt - a0, 3);
    chk("bb_accept_period", acc_gap, 31);
    chk("bb_rdata", v_rdata, 8'h5A);
    $display("back-to-back: accepts=%0d period=%0d", acc_cnt - a0, acc_gap);

    chk("inv_d_oe", doe_viol, 0);
    chk("inv_e_without_rw", e_rw_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_reader.md
# lcd_bus_reader

Read-side engine for the 16x2 HD44780-style character LCD on the 8-bit parallel bus. The command writer only ever drives the bus with RW=0; this block performs the opposite transfer. It runs RW=1 read cycles to fetch the busy flag and address counter (RS=0) or DDRAM/CGRAM data (RS=1), and can poll the busy flag until it clears. It sits between the LCD pads and any controller that must wait on BF instead of fixed delays, and shares RS/RW/E with the writer through an external arbiter that grants the bus to one side at a time.

## Interface
Parameters:
- T_AS, 3: RS/RW setup cycles before E rises (≥1)
- T_PW, 24: E high cycles; data sampled on the last one (≥1)
- T_H, 2: RS/RW hold cycles after E falls (≥1)
- T_REC, 24: extra E-low cycles between consecutive poll reads (≥1)
- POLL_MAX, 1024: maximum reads per poll operation (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- req  in  1  start request; accepted when req & ready
- op  in  2  00 read status once, 01 read data once, 10 poll BF until clear, 11 reserved (treated as 00)
- ready  out  1  idle and able to accept req
- valid  out  1  one-cycle pulse; rdata/timeout are final
- rdata  out  8  last sampled byte; for status reads [7]=BF, [6:0]=address counter
- timeout  out  1  poll ended with BF still 1; held until next accept
- d_in  in  8  LCD data pins (pad input)
- d_oe  out  1  pad drive enable; constantly 0 from this block
- RS  out  1  register select
- RW  out  1  read/write; 1 during an operation
- E  out  1  enable strobe

## Operation
- Reset values: ready=1, valid=0, rdata=8'h00, timeout=0, d_oe=0, RS=0, RW=0, E=0, state IDLE, poll count 0.
- States: IDLE, SETUP, EHIGH, HOLD, REC, DONE.
- IDLE: ready=1. On req, latch op. Drive RS = (op==01), drive RW=1, clear timeout and poll count, and go to SETUP. req is ignored in every other state.
- SETUP: T_AS cycles, then E=1 and go to EHIGH.
- EHIGH: T_PW cycles. On the edge that ends EHIGH, clear E, capture rdata<=d_in, increment poll count, and go to HOLD.
- HOLD: T_H cycles with RS/RW unchanged. Exit rules:
  - For op 10 with rdata[7]=1 and count<POLL_MAX, go to REC.
  - For op 10 with rdata[7]=1 and count==POLL_MAX, set timeout=1 and go to DONE.
  - Otherwise go to DONE.
- REC: T_REC cycles, then go to SETUP. RS stays 0 and RW stays 1.
- DONE: valid=1 for one cycle. RS and RW return to 0, then the block goes to IDLE.
- Phase counter width is $clog2(max(T_AS,T_PW,T_H,T_REC)+1). Poll counter width is $clog2(POLL_MAX+1). Neither counter may wrap.
- Reset mid-operation: all outputs return to reset values immediately, including E=0 asynchronously. An aborted read never produces valid.

## Timing
- Accept at edge k. RS and RW are valid from k.
- E=1 from edge k+T_AS through edge k+T_AS+T_PW. rdata is updated at k+T_AS+T_PW.
- valid is high in the cycle starting at k+T_AS+T_PW+T_H. RW=0 at that same edge. ready=1 one cycle later.
- With defaults, a single read gives E rising at k+3, E falling at k+27, valid at k+29, ready at k+30.
- Each additional poll iteration adds T_REC+T_AS+T_PW+T_H cycles. E-low time between reads is T_H+T_REC+T_AS.
- E is registered and glitch-free, and is never high while RW=0.

## Structure
- Package lcd_pkg holds:
  - op encodings: OP_STATUS, OP_DATA, OP_POLL
  - state enum: IDLE through DONE
  - default timing constants, shared with the writer
- Sub-module lcd_phase_timer is a loadable down-counter with load, value and expire outputs. It is reused for all timed states; the FSM and poll counter stay in lcd_bus_reader.

## Test plan
- Reset, then op=00 with d_in=8'h05 → E high exactly 24 cycles, rdata=8'h05, valid at k+29, timeout=0, RS=0 throughout.
- op=01 with d_in=8'h4A → RS=1 and RW=1 from k, rdata=8'h4A, RS and RW both 0 after valid.
- op=10 with d_in=8'h80 for 3 reads, then 8'h12 → exactly 4 E pulses, E-low gap of 29 cycles between them, rdata=8'h12, timeout=0.
- op=10 with POLL_MAX=4 and d_in fixed at 8'hFF → 4 E pulses, then valid with timeout=1 and rdata=8'hFF.
- Assert rst while E=1 during a poll → E, RW and RS go 0 without waiting for a clock edge, valid is never asserted, and ready=1. A new op=00 then completes normally.
- req held high continuously → back-to-back operations, one accept per ready cycle, d_oe=0 at all times.
